dice_roll_ctrl: RTL and testbench

DICE_ROLL_CTRL -- requirements
Module: dice_roll_ctrl

---
 rtl/dice_pkg.sv | 74 +++++++
 rtl/btn_debounce.sv | 70 +++++++
 rtl/dice_roll_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_dice_roll_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// -----------------------------------------------------------------------------
// dice_pkg
// Shared definitions for the dice roll controller:
//   - FSM state encoding (IDLE / ROLL / SLOW / DONE)
//   - display slot encoding used by the digit scanner
//   - active-low seven-segment codes for 0..9 and the blank code
//   - helpers for die value stepping, slot rotation and segment encoding
// -----------------------------------------------------------------------------
package dice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROLL = 2'd1,
        ST_SLOW = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Display slots in scan order; slot n drives CS bit (2 - n) low.
    localparam logic [1:0] SLOT_DIE  = 2'd0;
    localparam logic [1:0] SLOT_ONES = 2'd1;
    localparam logic [1:0] SLOT_TENS = 2'd2;

    // Active-low segments, bit7 = dp, bits6..0 = g..a.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;

    localparam logic [2:0] DIE_MIN = 3'd1;
    localparam logic [2:0] DIE_MAX = 3'd6;

    // Decimal digit to active-low segment pattern; anything above 9 is blank.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Die stepping 1..6 with wrap to 1; out-of-range values also recover to 1.
    function automatic logic [2:0] die_next(input logic [2:0] value);
        return ((value >= DIE_MAX) || (value < DIE_MIN)) ? DIE_MIN : value + 3'd1;
    endfunction

    // Scan order: die -> ones -> tens -> die.
    function automatic logic [1:0] slot_advance(input logic [1:0] slot);
        logic [1:0] nxt;
        case (slot)
            SLOT_DIE:  nxt = SLOT_ONES;
            SLOT_ONES: nxt = SLOT_TENS;
            default:   nxt = SLOT_DIE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer followed by a counting debouncer for an active-low
// push button. The debounced level only follows the synchronized input after
// DEB_CYC consecutive samples that differ from the current level.
//
// Parameters:
//   DEB_CYC  consecutive stable samples needed to accept a new level
// Ports:
//   ck     in   clock, rising edge
//   rst    in   asynchronous active-low reset
//   din    in   raw button input (asynchronous to ck)
//   level  out  debounced level (resets to 1 = released)
//   press  out  one-cycle pulse on a debounced 1->0 transition
//   rls    out  one-cycle pulse on a debounced 0->1 transition
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic ck,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic press,
    output logic rls
);

    localparam int              CW       = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic          rls_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            press_reg <= 1'b0;
            rls_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            rls_reg   <= 1'b0;
            // cnt_reg counts how many samples in a row have disagreed with
            // the accepted level; any agreeing sample restarts the run.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
                press_reg <= ~sync2_reg;
                rls_reg   <= sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;
    assign rls   = rls_reg;

endmodule

// File: rtl/dice_roll_ctrl.sv
// -----------------------------------------------------------------------------
// dice_roll_ctrl
// Electronic die: while the (active-low) button is held the die value spins
// every cycle; on release it slows down over SLOW_STEPS advances with a
// doubling interval, then settles. Each completed roll bumps a 0..99 counter.
//
// Build option:
//   DICE_STATS_EN defined   : roll counter built; die, count ones and count
//                             tens are time-multiplexed on the display with a
//                             blank first cycle in every slot.
//   DICE_STATS_EN undefined : no counter; the die digit is shown continuously
//                             on CS[2] (CS = 3'b011), no blanking.
//
// Parameters:
//   DEB_CYC     debounce length in cycles
//   SCAN_DIV    cycles per display slot
//   SLOW_BASE   first slow-down interval in cycles
//   SLOW_STEPS  number of advances in the slow-down phase
// Ports:
//   ck      in   clock, rising edge
//   rst     in   asynchronous active-low reset
//   enable  in   active-low roll button, asynchronous to ck
//   nSEG    out  active-low segments, bit7 = dp, bits6..0 = g..a (registered)
//   CS      out  active-low digit selects, [2] die, [1] ones, [0] tens
// -----------------------------------------------------------------------------
module dice_roll_ctrl
    import dice_pkg::*;
#(
    parameter int DEB_CYC    = 16,
    parameter int SCAN_DIV   = 1024,
    parameter int SLOW_BASE  = 256,
    parameter int SLOW_STEPS = 6
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       enable,
    output logic [7:0] nSEG,
    output logic [2:0] CS
);

    localparam int               STEP_W    = $clog2(SLOW_STEPS + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SLOW_STEPS - 1);
    localparam logic [15:0]       BASE_16   = 16'(SLOW_BASE);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic btn_level;
    logic press_evt;
    logic rls_evt;

    btn_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_btn (
        .ck    (ck),
        .rst   (rst),
        .din   (enable),
        .level (btn_level),
        .press (press_evt),
        .rls   (rls_evt)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t state_reg;
    state_t state_next;

    logic [2:0]        value_reg;
    logic [15:0]       interval_reg;
    logic [15:0]       timer_reg;
    logic [STEP_W-1:0] step_reg;

    logic roll_adv;
    logic slow_load;
    logic slow_tick;
`ifdef DICE_STATS_EN
    logic count_inc;
`endif

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            // The press pulse and the level always agree; checking the
            // level too keeps the entry condition self-consistent.
            ST_IDLE: if (press_evt && !btn_level) state_next = ST_ROLL;
            ST_ROLL: if (rls_evt) state_next = ST_SLOW;
            // Presses are not looked at here, so a second press while
            // slowing down has no effect.
            ST_SLOW: if (slow_tick && (step_reg == STEP_LAST)) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        roll_adv  = 1'b0;
        slow_load = 1'b0;
        slow_tick = 1'b0;
`ifdef DICE_STATS_EN
        count_inc = 1'b0;
`endif
        case (state_reg)
            ST_ROLL: begin
                roll_adv  = 1'b1;
                slow_load = rls_evt;
            end
            ST_SLOW: slow_tick = (timer_reg == (interval_reg - 16'd1));
`ifdef DICE_STATS_EN
            ST_DONE: count_inc = 1'b1;
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Die value and slow-down timing
    // ------------------------------------------------------------------
    logic [15:0] interval_dbl;

    // Doubling saturates once the top bit is set instead of wrapping.
    assign interval_dbl = interval_reg[15] ? 16'hFFFF : {interval_reg[14:0], 1'b0};

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            value_reg    <= DIE_MIN;
            interval_reg <= '0;
            timer_reg    <= '0;
            step_reg     <= '0;
        end else begin
            if (roll_adv || slow_tick) begin
                value_reg <= die_next(value_reg);
            end
            if (slow_load) begin
                interval_reg <= BASE_16;
                timer_reg    <= '0;
                step_reg     <= '0;
            end else if (state_reg == ST_SLOW) begin
                if (slow_tick) begin
                    timer_reg    <= '0;
                    interval_reg <= interval_dbl;
                    step_reg     <= step_reg + STEP_W'(1);
                end else begin
                    timer_reg <= timer_reg + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Display
    // ------------------------------------------------------------------
    logic [7:0] nseg_next;
    logic [2:0] cs_next;
    logic [7:0] nseg_reg;
    logic [2:0] cs_reg;

`ifdef DICE_STATS_EN
    localparam int             PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [3:0]    ones_reg;
    logic [3:0]    tens_reg;
    logic [PW-1:0] presc_reg;
    logic [1:0]    slot_reg;
    logic [3:0]    digit_sel;

    // BCD roll counter, 00..99 with wrap.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            ones_reg <= '0;
            tens_reg <= '0;
        end else if (count_inc) begin
            if (ones_reg >= 4'd9) begin
                ones_reg <= '0;
                tens_reg <= (tens_reg >= 4'd9) ? 4'd0 : tens_reg + 4'd1;
            end else begin
                ones_reg <= ones_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            presc_reg <= '0;
            slot_reg  <= SLOT_DIE;
        end else if (presc_reg == PRESC_LAST) begin
            presc_reg <= '0;
            slot_reg  <= slot_advance(slot_reg);
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    always_comb begin
        digit_sel = 4'hF;
        case (slot_reg)
            SLOT_DIE:  digit_sel = {1'b0, value_reg};
            SLOT_ONES: digit_sel = ones_reg;
            SLOT_TENS: digit_sel = tens_reg;
            default:   digit_sel = 4'hF;
        endcase
    end

    // Blank the first cycle of each slot so the previous digit never
    // ghosts onto the newly selected one.
    assign nseg_next = (presc_reg == '0) ? SEG_BLANK : seg_encode(digit_sel);

    // CS bit gi is low when the slot that maps onto it is active.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cs
        assign cs_next[gi] = (slot_reg != 2'(2 - gi));
    end
`else
    assign nseg_next = seg_encode({1'b0, value_reg});
    assign cs_next   = 3'b011;
`endif

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            nseg_reg <= SEG_BLANK;
            cs_reg   <= 3'b111;
        end else begin
            nseg_reg <= nseg_next;
            cs_reg   <= cs_next;
        end
    end

    assign nSEG = nseg_reg;
    assign CS   = cs_reg;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dice_roll_ctrl
// Directed bench for dice_roll_ctrl with default parameters. Expected die
// values follow from the hold length: every held cycle is one ROLL advance,
// plus SLOW_STEPS advances afterwards, counted modulo 6 from the value 1.
// -----------------------------------------------------------------------------
module tb_dice_roll_ctrl;

    logic       ck = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] nSEG;
    logic [2:0] CS;

    int checks = 0;
    int passed = 0;
    int chg_q[$];

    dice_roll_ctrl #(
        .DEB_CYC    (16),
        .SCAN_DIV   (1024),
        .SLOW_BASE  (256),
        .SLOW_STEPS (6)
    ) dut (
        .ck     (ck),
        .rst    (rst),
        .enable (enable),
        .nSEG   (nSEG),
        .CS     (CS)
    );

    always #5 ck = ~ck;

    // Capture the three displayed digits while the die is idle.
    task automatic read_digits(output logic [7:0] die, output logic [7:0] ones,
                               output logic [7:0] tens, output bit ok);
`ifdef DICE_STATS_EN
        bit got_d = 1'b0;
        bit got_o = 1'b0;
        bit got_t = 1'b0;
        die = 8'hFF; ones = 8'hFF; tens = 8'hFF;
        for (int i = 0; (i < 4 * 1024 + 8) && !(got_d && got_o && got_t); i++) begin
            @(negedge ck);
            if (nSEG !== 8'hFF) begin
                case (CS)
                    3'b011: begin die  = nSEG; got_d = 1'b1; end
                    3'b101: begin ones = nSEG; got_o = 1'b1; end
                    3'b110: begin tens = nSEG; got_t = 1'b1; end
                    default: ;
                endcase
            end
        end
        ok = got_d && got_o && got_t;
`else
        @(negedge ck);
        die  = nSEG;
        ones = 8'hFF;
        tens = 8'hFF;
        ok   = 1'b1;
`endif
    endtask

    // Hold the button for 'hold' cycles, release, and record the cycle of
    // every die-digit change for the next 16500 cycles. An optional extra
    // press of press_len cycles starts press_at cycles after the release.
    task automatic do_roll(input int hold, input int press_at, input int press_len);
        logic [7:0] prev;
        chg_q.delete();
        @(negedge ck);
        enable = 1'b0;
        repeat (hold) @(negedge ck);
        enable = 1'b1;
        prev = nSEG;
        for (int cyc = 1; cyc <= 16500; cyc++) begin
            @(negedge ck);
            if (press_len > 0 && cyc == press_at) enable = 1'b0;
            if (press_len > 0 && cyc == press_at + press_len) enable = 1'b1;
`ifdef DICE_STATS_EN
            if (CS === 3'b011 && nSEG !== 8'hFF && nSEG !== prev) begin
                chg_q.push_back(cyc);
                prev = nSEG;
            end
`else
            if (nSEG !== prev) begin
                chg_q.push_back(cyc);
                prev = nSEG;
            end
`endif
        end
        enable = 1'b1;
    endtask

    // Slow-down gaps: the last six changes must follow the last ROLL change
    // by 256, 512, 1024, 2048, 4096, 8192 cycles.
    task automatic check_gaps(input string tag);
`ifndef DICE_STATS_EN
        int n;
        int gap;
        n = chg_q.size();
        checks++;
        if (n < 7) begin
            $display("FAIL %s_changes: saw %0d digit changes, need at least 7", tag, n);
        end else begin
            passed++;
            for (int k = 0; k < 6; k++) begin
                gap = chg_q[n - 6 + k] - chg_q[n - 7 + k];
                checks++;
                if (gap !== (256 << k))
                    $display("FAIL %s_gap%0d: got %0d cycles, expected %0d", tag, k, gap, 256 << k);
                else passed++;
            end
        end
`else
        $display("INFO %s: gap timing only measured in the single-digit build", tag);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge ck);
        checks++;
        if (nSEG !== 8'hFF) $display("FAIL reset_nseg: got %h, expected ff", nSEG); else passed++;
        checks++;
        if (CS !== 3'b111) $display("FAIL reset_cs: got %b, expected 111", CS); else passed++;
        rst = 1'b1;
        @(negedge ck);
        checks++;
        if (CS !== 3'b011) $display("FAIL first_cs: got %b, expected 011", CS); else passed++;
`ifdef DICE_STATS_EN
        checks++;
        if (nSEG !== 8'hFF) $display("FAIL first_blank: got %h, expected ff", nSEG); else passed++;
        @(negedge ck);
`endif
        checks++;
        if (nSEG !== 8'hF9) $display("FAIL first_die: got %h, expected f9", nSEG); else passed++;
        $display("INFO test_reset done");
    endtask

    task automatic test_idle_hold();
        logic [7:0] d, o, t;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            repeat (1000) @(negedge ck);
`ifndef DICE_STATS_EN
            checks++;
            if (nSEG !== 8'hF9) $display("FAIL idle_die_%0d: got %h, expected f9", i, nSEG); else passed++;
            checks++;
            if (CS !== 3'b011) $display("FAIL idle_cs_%0d: got %b, expected 011", i, CS); else passed++;
`endif
        end
        read_digits(d, o, t, ok);
        checks++;
        if (d !== 8'hF9) $display("FAIL idle_die: got %h, expected f9", d); else passed++;
`ifdef DICE_STATS_EN
        checks++;
        if (!ok) $display("FAIL idle_scan: got incomplete scan, expected all three slots"); else passed++;
        checks++;
        if (o !== 8'hC0) $display("FAIL idle_ones: got %h, expected c0", o); else passed++;
        checks++;
        if (t !== 8'hC0) $display("FAIL idle_tens: got %h, expected c0", t); else passed++;
`endif
        $display("INFO test_idle_hold done");
    endtask

    task automatic test_short_pulse();
        logic [7:0] d, o, t;
        bit ok;
        int moved = 0;
        @(negedge ck);
        enable = 1'b0;
        repeat (10) @(negedge ck);
        enable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge ck);
            if (CS === 3'b011 && nSEG !== 8'hFF && nSEG !== 8'hF9) moved++;
        end
        checks++;
        if (moved !== 0) $display("FAIL glitch_moved: got %0d changed cycles, expected 0", moved); else passed++;
        read_digits(d, o, t, ok);
        checks++;
        if (d !== 8'hF9) $display("FAIL glitch_die: got %h, expected f9", d); else passed++;
        $display("INFO test_short_pulse done");
    endtask

    // 100 ROLL + 6 SLOW advances from 1: 106 mod 6 = 4 -> value 5.
    task automatic test_roll();
        logic [7:0] d, o, t;
        bit ok;
        do_roll(100, 0, 0);
        check_gaps("roll");
        read_digits(d, o, t, ok);
        checks++;
        if (d !== 8'h92) $display("FAIL roll_die: got %h, expected 92", d); else passed++;
`ifdef DICE_STATS_EN
        checks++;
        if (o !== 8'hF9) $display("FAIL roll_ones: got %h, expected f9", o); else passed++;
        checks++;
        if (t !== 8'hC0) $display("FAIL roll_tens: got %h, expected c0", t); else passed++;
`endif
        $display("INFO test_roll done");
    endtask

    // From value 5 (index 4): +106 -> index 2 -> value 3.
    task automatic test_press_in_slow();
        logic [7:0] d, o, t;
        bit ok;
        do_roll(100, 3000, 40);
        check_gaps("slowpress");
        read_digits(d, o, t, ok);
        checks++;
        if (d !== 8'hB0) $display("FAIL slowpress_die: got %h, expected b0", d); else passed++;
`ifdef DICE_STATS_EN
        checks++;
        if (o !== 8'hA4) $display("FAIL slowpress_ones: got %h, expected a4", o); else passed++;
        checks++;
        if (t !== 8'hC0) $display("FAIL slowpress_tens: got %h, expected c0", t); else passed++;
`endif
        $display("INFO test_press_in_slow done");
    endtask

    task automatic test_count_wrap();
`ifdef DICE_STATS_EN
        logic [7:0] d, o, t;
        bit ok;
        @(negedge ck);
        force dut.ones_reg = 4'd9;
        force dut.tens_reg = 4'd9;
        @(negedge ck);
        release dut.ones_reg;
        release dut.tens_reg;
        read_digits(d, o, t, ok);
        checks++;
        if (o !== 8'h90 || t !== 8'h90) $display("FAIL wrap_preset: got %h %h, expected 90 90", t, o); else passed++;
        // From value 3 (index 2): +36 -> index 2 -> value 3.
        do_roll(30, 0, 0);
        read_digits(d, o, t, ok);
        checks++;
        if (d !== 8'hB0) $display("FAIL wrap_die: got %h, expected b0", d); else passed++;
        checks++;
        if (o !== 8'hC0) $display("FAIL wrap_ones: got %h, expected c0", o); else passed++;
        checks++;
        if (t !== 8'hC0) $display("FAIL wrap_tens: got %h, expected c0", t); else passed++;
        $display("INFO test_count_wrap done");
`else
        $display("INFO test_count_wrap: no roll counter in this build");
`endif
    endtask

    task automatic test_reset_in_slow();
        logic [7:0] d, o, t;
        bit ok;
        @(negedge ck);
        enable = 1'b0;
        repeat (50) @(negedge ck);
        enable = 1'b1;
        repeat (600) @(negedge ck);
        rst = 1'b0;
        #1;
        checks++;
        if (nSEG !== 8'hFF) $display("FAIL rstslow_nseg: got %h, expected ff", nSEG); else passed++;
        checks++;
        if (CS !== 3'b111) $display("FAIL rstslow_cs: got %b, expected 111", CS); else passed++;
        repeat (3) @(negedge ck);
        rst = 1'b1;
        repeat (2000) @(negedge ck);
        read_digits(d, o, t, ok);
        checks++;
        if (d !== 8'hF9) $display("FAIL rstslow_die: got %h, expected f9", d); else passed++;
`ifdef DICE_STATS_EN
        checks++;
        if (o !== 8'hC0 || t !== 8'hC0) $display("FAIL rstslow_count: got %h %h, expected c0 c0", t, o); else passed++;
`else
        checks++;
        if (CS !== 3'b011) $display("FAIL rstslow_cs_after: got %b, expected 011", CS); else passed++;
`endif
        $display("INFO test_reset_in_slow done");
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_short_pulse();
        test_roll();
        test_press_in_slow();
        test_count_wrap();
        test_reset_in_slow();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
